// File: rtl/controle_multiciclo.sv
// Multi-cycle nRISC control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory timeout.
// Optional performance counters are enabled by defining CTRL_PERF_EN.
module controle_multiciclo #(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15
`ifdef CTRL_PERF_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                instr_load,
  output logic [9:0]          decoded_instruction,
  output logic                illegal,
  output logic                fault,
  output logic                halted
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    retired,
  output logic [CNT_W-1:0]    stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam int WC_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  // Non-strobe fields: ulaop, jump, ulasrc, beq, regsrc
  localparam logic [9:0] NS_MASK = 10'b1111011100;
  localparam logic [9:0] WB_MASK = 10'b0000000011;
  localparam int         MW_BIT  = 5;

  state_e           state_q, state_d;
  logic [9:0]       ctrl_q, ctrl_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;

  logic             op_bad;
  logic [2:0]       op_lo;
  logic             is_halt;
  logic             waiting;
  logic             tmo_hit;

  function automatic logic [9:0] dec_word(input logic [2:0] op);
    logic [9:0] w;
    case (op)
      3'b000:  w = 10'b0000010011;
      3'b001:  w = 10'b0010010111;
      3'b010:  w = 10'b0100110101;
      3'b011:  w = 10'b0110000111;
      3'b100:  w = 10'b1000010111;
      3'b101:  w = 10'b1011001001;
      3'b110:  w = 10'b1101001001;
      default: w = 10'b0000000000;
    endcase
    return w;
  endfunction

  generate
    if (OPCODE_W > 3) begin : g_wide
      assign op_bad = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow
      assign op_bad = 1'b0;
    end
  endgenerate

  assign op_lo   = opcode[2:0];
  assign is_halt = !op_bad && (op_lo == 3'b111);
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM))
                   && !mem_ready;
  assign tmo_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WC_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_DECODE: begin
        if (op_bad)       state_d = S_FETCH;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = ctrl_q[MW_BIT] ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ready)    state_d = S_WB;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if ((state_q == S_DECODE) && !op_bad && !is_halt) begin
      ctrl_d = dec_word(op_lo);
    end
  end

  // Counter restarts whenever the state changes, so it clears on FETCH/MEM entry.
  always_comb begin
    wait_cnt_d = '0;
    if (waiting && (state_d == state_q)) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q
                                      : wait_cnt_q + 1'b1;
    end
  end

  assign fault_d = fault_q || (waiting && tmo_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q     <= '0;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    mem_req             = 1'b0;
    instr_load          = 1'b0;
    decoded_instruction = '0;
    illegal             = 1'b0;
    halted              = 1'b0;
    fault               = fault_q;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        instr_load = mem_ready;
      end
      S_DECODE: begin
        illegal = op_bad;
      end
      S_EXEC: begin
        decoded_instruction = ctrl_q & NS_MASK;
      end
      S_MEM: begin
        mem_req             = 1'b1;
        decoded_instruction = ctrl_q & NS_MASK;
        decoded_instruction[MW_BIT] = ctrl_q[MW_BIT] && mem_ready;
      end
      S_WB: begin
        decoded_instruction = ctrl_q & (NS_MASK | WB_MASK);
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req             = 1'b0;
      instr_load          = 1'b0;
      decoded_instruction = '0;
      illegal             = 1'b0;
      halted              = 1'b0;
      fault               = 1'b0;
    end
  end

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    ret_d   = ret_q;
    stall_d = stall_q;
    if ((state_q == S_WB) && (ret_q != '1)) begin
      ret_d = ret_q + 1'b1;
    end
    if (waiting && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign retired      = reset ? '0 : ret_q;
  assign stall_cycles = reset ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo (OPCODE_W=4, MEM_TIMEOUT=4).
// Perf counters are checked when CTRL_PERF_EN is defined.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, instr_load, illegal, fault, halted;
  logic [9:0] decoded_instruction;
`ifdef CTRL_PERF_EN
  logic [15:0] retired, stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;
  int exp_stl = 0;
  logic [14:0] exp_q[$];

  controle_multiciclo #(
    .OPCODE_W   (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .clock              (clk),
    .reset              (reset),
    .opcode             (opcode),
    .mem_ready          (mem_ready),
    .mem_req            (mem_req),
    .instr_load         (instr_load),
    .decoded_instruction(decoded_instruction),
    .illegal            (illegal),
    .fault              (fault),
    .halted             (halted)
`ifdef CTRL_PERF_EN
    ,
    .retired            (retired),
    .stall_cycles       (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] tbl(input logic [2:0] op);
    case (op)
      3'd0: return 10'b0000010011;
      3'd1: return 10'b0010010111;
      3'd2: return 10'b0100110101;
      3'd3: return 10'b0110000111;
      3'd4: return 10'b1000010111;
      3'd5: return 10'b1011001001;
      3'd6: return 10'b1101001001;
      default: return 10'b0;
    endcase
  endfunction

  // {mem_req, instr_load, decoded[9:0], illegal, fault, halted}
  function automatic logic [14:0] ev(input logic rq, input logic ld,
                                     input logic [9:0] d,
                                     input logic [2:0] ifh);
    return {rq, ld, d, ifh};
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic step(input string tag, input logic rst,
                      input logic [3:0] op, input logic rdy,
                      input logic [14:0] e,
                      input bit iret, input bit istl);
    logic [14:0] x;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk(tag, 32'({mem_req, instr_load, decoded_instruction,
                  illegal, fault, halted}), 32'(x));
`ifdef CTRL_PERF_EN
    chk({tag, ".ret"}, 32'(retired), rst ? 32'd0 : 32'(exp_ret));
    chk({tag, ".stl"}, 32'(stall_cycles), rst ? 32'd0 : 32'(exp_stl));
`endif
    if (rst) begin
      exp_ret = 0;
      exp_stl = 0;
    end else begin
      exp_ret += int'(iret);
      exp_stl += int'(istl);
    end
  endtask

  task automatic do_reset();
    step("reset", 1'b1, rop(), rbit(), '0, 1'b0, 1'b0);
  endtask

  // mw >= 4 runs the store into a MEM timeout; rst_mem resets during MEM.
  task automatic instr(input logic [3:0] op, input int fw,
                       input int mw, input bit rst_mem);
    logic [9:0] w, ns;
    w  = tbl(op[2:0]);
    ns = w & 10'b1111011100;
    for (int i = 0; i < fw; i++)
      step("fetch_wait", 1'b0, rop(), 1'b0,
           ev(1, 0, '0, 3'b000), 1'b0, 1'b1);
    step("fetch", 1'b0, rop(), 1'b1, ev(1, 1, '0, 3'b000), 1'b0, 1'b0);
    step("decode", 1'b0, op, rbit(),
         ev(0, 0, '0, {op[3], 2'b00}), 1'b0, 1'b0);
    if (op[3] || op == 4'd7) return;
    step("exec", 1'b0, rop(), rbit(), ev(0, 0, ns, 3'b000), 1'b0, 1'b0);
    if (w[5]) begin
      if (rst_mem) begin
        step("mem_wait", 1'b0, rop(), 1'b0,
             ev(1, 0, ns, 3'b000), 1'b0, 1'b1);
        do_reset();
        return;
      end
      for (int i = 0; i < (mw >= 4 ? 4 : mw); i++)
        step("mem_wait", 1'b0, rop(), 1'b0,
             ev(1, 0, ns, 3'b000), 1'b0, 1'b1);
      if (mw >= 4) return;
      step("mem", 1'b0, rop(), 1'b1,
           ev(1, 0, ns | 10'b0000100000, 3'b000), 1'b0, 1'b0);
    end
    step("wb", 1'b0, rop(), rbit(),
         ev(0, 0, ns | (w & 10'b11), 3'b000), 1'b1, 1'b0);
  endtask

  task automatic halt_cycles(input int n, input logic f);
    for (int i = 0; i < n; i++)
      step(f ? "halt_fault" : "halt", 1'b0, rop(), rbit(),
           ev(0, 0, '0, {1'b0, f, 1'b1}), 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    for (int k = 0; k < 3; k++) instr(4'd0, 0, 0, 1'b0);
    instr(4'd2, 0, 3, 1'b0);
    for (int op = 0; op < 7; op++)
      instr(4'(op), op % 3, (op == 2) ? 1 : 0, 1'b0);
    instr(4'b1000, 0, 0, 1'b0);
    instr(4'b1111, 1, 0, 1'b0);
    instr(4'd3, 0, 0, 1'b0);
    instr(4'd2, 3, 0, 1'b0);
    instr(4'd2, 0, 0, 1'b1);
    instr(4'd1, 0, 0, 1'b0);
    instr(4'd7, 0, 0, 1'b0);
    halt_cycles(20, 1'b0);
    do_reset();
    instr(4'd0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("fetch_tmo", 1'b0, rop(), 1'b0,
           ev(1, 0, '0, 3'b000), 1'b0, 1'b1);
    halt_cycles(5, 1'b1);
    do_reset();
    instr(4'd2, 0, 4, 1'b0);
    halt_cycles(5, 1'b1);
    do_reset();
    instr(4'd5, 1, 0, 1'b0);
    instr(4'd6, 0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
